// File: rtl/hdmi_out_pixel_reader_pkg.sv
// Shared definitions for the HDMI output pixel reader: default pixel format,
// standard timing-mode constants, reader FSM states and a saturating helper.
package hdmi_out_pixel_reader_pkg;

  localparam int          DATA_WIDTH_DEF = 24;
  localparam logic [23:0] UF_COLOR_DEF   = 24'h000000;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
  localparam int T720_H_ACTIVE = 1280;
  localparam int T720_H_FP     = 110;
  localparam int T720_H_SYNC   = 40;
  localparam int T720_H_BP     = 220;
  localparam int T720_V_ACTIVE = 720;
  localparam int T720_V_FP     = 5;
  localparam int T720_V_SYNC   = 5;
  localparam int T720_V_BP     = 20;

  // 1920x1080 @ 60 Hz (148.5 MHz pixel clock)
  localparam int T1080_H_ACTIVE = 1920;
  localparam int T1080_H_FP     = 88;
  localparam int T1080_H_SYNC   = 44;
  localparam int T1080_H_BP     = 148;
  localparam int T1080_V_ACTIVE = 1080;
  localparam int T1080_V_FP     = 4;
  localparam int T1080_V_SYNC   = 5;
  localparam int T1080_V_BP     = 36;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FILL = 2'd1,
    ST_RUN       = 2'd2
  } rd_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hdmi_out_pixel_reader_if.sv
// Show-ahead FIFO read port: the reader (master) pops with fifo_rd_en while
// the FIFO (slave) presents its head word on fifo_rd_data / fifo_rd_vld.
interface hdmi_out_pixel_reader_if
  import hdmi_out_pixel_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  fifo_rd_en;
  logic                  fifo_rd_vld;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  modport master (output fifo_rd_en, input fifo_rd_vld, input fifo_rd_data);
  modport slave  (input fifo_rd_en, output fifo_rd_vld, output fifo_rd_data);
endinterface

// File: rtl/hdmi_out_pixel_reader_video_timing_gen.sv
// Horizontal/vertical raster counters and the combinational timing strobes
// derived from them. Line order is active, front porch, sync, back porch.
module video_timing_gen
  import hdmi_out_pixel_reader_pkg::*;
#(
  parameter int   H_ACTIVE = T720_H_ACTIVE,
  parameter int   H_FP     = T720_H_FP,
  parameter int   H_SYNC   = T720_H_SYNC,
  parameter int   H_BP     = T720_H_BP,
  parameter int   V_ACTIVE = T720_V_ACTIVE,
  parameter int   V_FP     = T720_V_FP,
  parameter int   V_SYNC   = T720_V_SYNC,
  parameter int   V_BP     = T720_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic active_o,
  output logic hs_o,
  output logic vs_o,
  output logic frame_first_o,
  output logic frame_end_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  // Raster position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Next position: clear wins, otherwise advance with line/frame wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (clr_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (en_i) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Strobes decoded from the current position; vs only moves when v_cnt
  // does, which is always at h_cnt=0, so it is line-aligned by construction.
  always_comb begin
    active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_o          = ((h_cnt_q >= H_HS_BEG) && (h_cnt_q < H_HS_END)) ? HS_POL : ~HS_POL;
    vs_o          = ((v_cnt_q >= V_VS_BEG) && (v_cnt_q < V_VS_END)) ? VS_POL : ~VS_POL;
    frame_first_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_end_o   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  end

endmodule

// File: rtl/hdmi_out_pixel_reader.sv
// Pulls pixels from the HDMI prefetch FIFO in step with the video raster and
// presents registered hs/vs/de/rgb to the TMDS encoder. A missing pixel is
// replaced by UF_COLOR so the raster never slips; the loss is counted.
module hdmi_out_pixel_reader
  import hdmi_out_pixel_reader_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    H_ACTIVE   = T720_H_ACTIVE,
  parameter int                    H_FP       = T720_H_FP,
  parameter int                    H_SYNC     = T720_H_SYNC,
  parameter int                    H_BP       = T720_H_BP,
  parameter int                    V_ACTIVE   = T720_V_ACTIVE,
  parameter int                    V_FP       = T720_V_FP,
  parameter int                    V_SYNC     = T720_V_SYNC,
  parameter int                    V_BP       = T720_V_BP,
  parameter logic                  HS_POL     = 1'b1,
  parameter logic                  VS_POL     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] UF_COLOR   = DATA_WIDTH'(UF_COLOR_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  hdmi_out_pixel_reader_if.master fifo,
  output logic                   hs,
  output logic                   vs,
  output logic                   de,
  output logic [DATA_WIDTH-1:0]  rgb,
  output logic                   frame_start,
  output logic                   underflow,
  output logic [15:0]            uf_count
);
  rd_state_t state_q, state_d;

  logic run_c, active_c, hs_c, vs_c, frame_first_c, frame_end_c, pop_c;

  logic                  hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic                  fs_q, fs_d, uf_q, uf_d;
  logic [15:0]           ufc_q, ufc_d;

  assign run_c = (state_q == ST_RUN);

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (run_c),
    .clr_i         (~run_c),
    .active_o      (active_c),
    .hs_o          (hs_c),
    .vs_o          (vs_c),
    .frame_first_o (frame_first_c),
    .frame_end_o   (frame_end_c)
  );

  // Pop only a valid head word and only inside the active window.
  assign pop_c           = run_c && active_c && fifo.fifo_rd_vld;
  assign fifo.fifo_rd_en = pop_c;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: start only once data is waiting; stop only between frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_WAIT_FILL;
      ST_WAIT_FILL: begin
        if (!enable)                state_d = ST_IDLE;
        else if (fifo.fifo_rd_vld)  state_d = ST_RUN;
      end
      ST_RUN:       if (!enable && frame_end_c) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output and underflow next values; outside RUN the video lines idle.
  always_comb begin
    hs_d  = ~HS_POL;
    vs_d  = ~VS_POL;
    de_d  = 1'b0;
    rgb_d = '0;
    fs_d  = 1'b0;
    uf_d  = uf_q;
    ufc_d = ufc_q;
    if (run_c) begin
      hs_d = hs_c;
      vs_d = vs_c;
      de_d = active_c;
      fs_d = frame_first_c;
      if (pop_c) begin
        rgb_d = fifo.fifo_rd_data;
      end else if (active_c) begin
        rgb_d = UF_COLOR;
        uf_d  = 1'b1;
        ufc_d = sat_inc16(ufc_q);
      end
    end
  end

  // Output register stage: one clock behind the raster position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
      fs_q  <= 1'b0;
      uf_q  <= 1'b0;
      ufc_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
      uf_q  <= uf_d;
      ufc_q <= ufc_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign uf_count    = ufc_q;

endmodule

// File: tb/tb_hdmi_out_pixel_reader.sv
// Directed bench for hdmi_out_pixel_reader on a tiny 8x6 raster, plus a
// second instance on a large raster to drive the underflow counter into
// saturation.
module tb_hdmi_out_pixel_reader;
  localparam logic [23:0] UFC = 24'hFF00FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n, enable, enable2, vld2, fifo_clr;
  logic hs, vs, de, fs, underflow;
  logic [23:0] rgb;
  logic [15:0] uf_count;
  logic hs2, vs2, de2, fs2, underflow2;
  logic [23:0] rgb2;
  logic [15:0] uf2;

  int checks = 0;
  int errors = 0;

  // FIFO model for the small instance: show-ahead, pops on rd_en.
  logic [23:0] mem [0:15];
  int wr_cnt = 0;
  int rd_ptr = 0;
  int n_de2 = 0;

  hdmi_out_pixel_reader_if #(.DATA_WIDTH(24)) fif ();
  hdmi_out_pixel_reader_if #(.DATA_WIDTH(24)) fif2 ();

  assign fif.fifo_rd_vld   = (rd_ptr < wr_cnt);
  assign fif.fifo_rd_data  = mem[rd_ptr[3:0]];
  assign fif2.fifo_rd_vld  = vld2;
  assign fif2.fifo_rd_data = 24'h000000;

  always @(posedge clk) begin
    if (fifo_clr)            rd_ptr <= 0;
    else if (fif.fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  always @(posedge clk) begin
    if (!rst2_n)  n_de2 <= 0;
    else if (de2) n_de2 <= n_de2 + 1;
  end

  hdmi_out_pixel_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .UF_COLOR(UFC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(fif.master),
    .hs(hs), .vs(vs), .de(de), .rgb(rgb), .frame_start(fs),
    .underflow(underflow), .uf_count(uf_count)
  );

  hdmi_out_pixel_reader #(
    .DATA_WIDTH(24), .H_ACTIVE(256), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(256), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .UF_COLOR(24'h000000)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(enable2), .fifo(fif2.master),
    .hs(hs2), .vs(vs2), .de(de2), .rgb(rgb2), .frame_start(fs2),
    .underflow(underflow2), .uf_count(uf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) mem[i] = base + 24'(i);
    wr_cnt = n;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    wr_cnt   = 0;
    step();
    step();
    fifo_clr = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic wait_de();
    for (int i = 0; i < 10 && de !== 1'b1; i++) step();
    chk("wait_de", 32'(de), 32'd1);
  endtask

  // Walks one 48-clock frame starting at the first de=1 sample. Sample k
  // shows raster position k: h=k%8, v=k/8. Active h<4,v<3; hs at h=5,6;
  // vs on line 4. Pixels beyond navail come out as UFC.
  task automatic check_frame(input int navail, input logic [23:0] base, input int drop_at);
    int pi;
    int ufe;
    pi  = 0;
    ufe = 0;
    for (int k = 0; k < 48; k++) begin
      int h, v;
      logic ede, ehs, evs;
      logic [23:0] ergb;
      h    = k % 8;
      v    = k / 8;
      ede  = (h < 4) && (v < 3);
      ehs  = (h == 5) || (h == 6);
      evs  = (v == 4);
      ergb = 24'h0;
      if (ede) begin
        if (pi < navail) ergb = base + 24'(pi);
        else begin
          ergb = UFC;
          ufe++;
        end
        pi++;
      end
      chk("de", 32'(de), 32'(ede));
      chk("hs", 32'(hs), 32'(ehs));
      chk("vs", 32'(vs), 32'(evs));
      chk("rgb", 32'(rgb), 32'(ergb));
      chk("frame_start", 32'(fs), 32'(k == 0));
      chk("uf_count", 32'(uf_count), 32'(ufe));
      chk("underflow", 32'(underflow), 32'(ufe > 0));
      if (k == drop_at) enable = 1'b0;
      step();
    end
  endtask

  initial begin
    int prev;
    logic wrapped;
    rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b0; enable2 = 1'b1;
    vld2 = 1'b0; fifo_clr = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 24'h0;
    step();
    step();
    // reset state
    chk("rst_hs", 32'(hs), 32'd0);
    chk("rst_vs", 32'(vs), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_ufc", 32'(uf_count), 32'd0);
    chk("rst2_hs", 32'(hs2), 32'd0);
    chk("rst2_vs", 32'(vs2), 32'd0);
    chk("rst2_fs", 32'(fs2), 32'd0);
    fifo_clr = 1'b0;
    rst_n = 1'b1; rst2_n = 1'b1;
    enable = 1'b1;
    step();
    // start the saturation instance with a single-cycle valid, then starve it
    vld2 = 1'b1;
    step();
    vld2 = 1'b0;

    // enable with empty FIFO: no pops, idle video lines
    for (int i = 0; i < 50; i++) begin
      chk("empty_rd_en", 32'(fif.fifo_rd_en), 32'd0);
      chk("empty_de", 32'(de), 32'd0);
      chk("empty_hs", 32'(hs), 32'd0);
      chk("empty_vs", 32'(vs), 32'd0);
      step();
    end

    // full frame of 12 pixels, exact start latency
    load_fifo(12, 24'h000001);
    chk("wf_rd_en", 32'(fif.fifo_rd_en), 32'd0);
    step();
    chk("run_rd_en", 32'(fif.fifo_rd_en), 32'd1);
    chk("run_de0", 32'(de), 32'd0);
    step();
    check_frame(12, 24'h000001, -1);
    chk("full_pops", 32'(rd_ptr), 32'd12);

    // FIFO runs dry after 5 pixels
    apply_reset();
    load_fifo(5, 24'h000001);
    wait_de();
    check_frame(5, 24'h000001, -1);
    chk("uf_pops", 32'(rd_ptr), 32'd5);

    // enable dropped on line 1: frame completes, then idle with data waiting
    apply_reset();
    enable = 1'b1;
    load_fifo(16, 24'h000010);
    wait_de();
    check_frame(16, 24'h000010, 10);
    for (int i = 0; i < 10; i++) begin
      chk("stop_de", 32'(de), 32'd0);
      chk("stop_rd_en", 32'(fif.fifo_rd_en), 32'd0);
      chk("stop_hs", 32'(hs), 32'd0);
      step();
    end
    chk("stop_pops", 32'(rd_ptr), 32'd12);

    // asynchronous reset at h_cnt=2 of line 1
    enable = 1'b1;
    apply_reset();
    load_fifo(12, 24'h000021);
    wait_de();
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_de", 32'(de), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_de", 32'(de), 32'd0);
    chk("arst_hs", 32'(hs), 32'd0);
    chk("arst_vs", 32'(vs), 32'd0);
    chk("arst_rgb", 32'(rgb), 32'd0);
    chk("arst_rd_en", 32'(fif.fifo_rd_en), 32'd0);
    fifo_clr = 1'b1;
    wr_cnt = 0;
    step();
    step();
    fifo_clr = 1'b0;
    rst_n = 1'b1;
    load_fifo(12, 24'h000031);
    wait_de();
    check_frame(12, 24'h000031, -1);

    // sustained underflow on the large instance
    prev = 32'(uf2);
    wrapped = 1'b0;
    for (int i = 0; i < 90000 && n_de2 < 70000; i++) begin
      step();
      if (32'(uf2) < prev) wrapped = 1'b1;
      prev = 32'(uf2);
    end
    chk("sat_reached_70000", 32'(n_de2 >= 70000), 32'd1);
    chk("sat_no_wrap", 32'(wrapped), 32'd0);
    chk("sat_uf_count", 32'(uf2), 32'h0000FFFF);
    chk("sat_underflow", 32'(underflow2), 32'd1);
    chk("sat_rgb", 32'(rgb2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
